// File: rtl/uart_core_param.sv
// Parametrised UART core (DATA_BITS/PARITY/STOP_BITS/CLKS_PER_BIT) with synchronised, glitch-filtered RX.
// Latency: tx starts one cycle after accept; rx pulses one cycle after the mid-stop-bit sample.
// Backpressure: transmit is honoured only while tx_ready=1; RX has none, every frame produces one pulse.
module uart_core_param #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 transmit,
  input  logic [DATA_BITS-1:0] tx_byte,
  output logic                 tx_ready,
  output logic                 received,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 parity_error,
  output logic                 recv_error,
  output logic                 is_receiving,
  output logic                 is_transmitting
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = 4;
  localparam logic [TW-1:0] BIT_END   = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_END  = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_ERROR} rx_state_t;

  // Reset asserts asynchronously but is released on a clock edge.
  logic rst_meta, rst_sync_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_meta   <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta   <= 1'b1;
      rst_sync_n <= rst_meta;
    end
  end

  // ---------------- transmitter ----------------
  tx_state_t              tx_state, tx_next;
  logic [TW-1:0]          tx_timer;
  logic [BW-1:0]          tx_bit;
  logic [DATA_BITS-1:0]   tx_shift;
  logic                   tx_par;
  logic                   tx_bit_end;
  logic                   tx_accept;

  assign tx_bit_end = (tx_timer == BIT_END);
  assign tx_accept  = (tx_state == TX_IDLE) && transmit;

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) tx_state <= TX_IDLE;
    else             tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:   if (transmit) tx_next = TX_START;
      TX_START:  if (tx_bit_end) tx_next = TX_DATA;
      TX_DATA:   if (tx_bit_end && tx_bit == DATA_LAST)
                   tx_next = (PARITY != 0) ? TX_PARITY : TX_STOP;
      TX_PARITY: if (tx_bit_end) tx_next = TX_STOP;
      TX_STOP:   if (tx_bit_end && tx_bit == STOP_LAST) tx_next = TX_IDLE;
      default:   tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    tx              = 1'b1;
    tx_ready        = (tx_state == TX_IDLE);
    is_transmitting = (tx_state != TX_IDLE);
    case (tx_state)
      TX_START:  tx = 1'b0;
      TX_DATA:   tx = tx_shift[0];
      TX_PARITY: tx = tx_par;
      default:   tx = 1'b1;
    endcase
  end

  // tx_bit counts data bits and stop bits; it clears whenever the state changes.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      tx_timer <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
    end else if (tx_accept) begin
      tx_timer <= '0;
      tx_bit   <= '0;
      tx_shift <= tx_byte;
      tx_par   <= (PARITY == 1) ? ~(^tx_byte) : (^tx_byte);
    end else if (tx_state != TX_IDLE) begin
      if (tx_bit_end) begin
        tx_timer <= '0;
        tx_bit   <= (tx_next != tx_state) ? '0 : tx_bit + BW'(1);
        if (tx_state == TX_DATA) tx_shift <= tx_shift >> 1;
      end else begin
        tx_timer <= tx_timer + TW'(1);
      end
    end
  end

  // ---------------- receiver ----------------
  rx_state_t              rx_state, rx_next;
  logic                   rx_meta, rx_s;
  logic [TW-1:0]          rx_timer;
  logic [TW-1:0]          rx_hi_cnt;
  logic [BW-1:0]          rx_bit;
  logic [DATA_BITS-1:0]   rx_shift;
  logic                   rx_par_bit;
  logic                   rx_tick, rx_half, rx_stop_tick, rx_par_bad;

  assign rx_tick      = (rx_timer == BIT_END);
  assign rx_half      = (rx_timer == HALF_END);
  assign rx_stop_tick = (rx_state == RX_STOP) && rx_tick;

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) rx_state <= RX_IDLE;
    else             rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:   if (!rx_s) rx_next = RX_START;
      RX_START:  if (rx_half) rx_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:   if (rx_tick && rx_bit == DATA_LAST)
                   rx_next = (PARITY != 0) ? RX_PARITY : RX_STOP;
      RX_PARITY: if (rx_tick) rx_next = RX_STOP;
      RX_STOP:   if (rx_tick) rx_next = rx_s ? RX_IDLE : RX_ERROR;
      RX_ERROR:  if (rx_s && rx_hi_cnt == BIT_END) rx_next = RX_IDLE;
      default:   rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    is_receiving = (rx_state != RX_IDLE);
  end

  always_comb begin
    rx_par_bad = 1'b0;
    if (PARITY == 1)      rx_par_bad = ~((^rx_shift) ^ rx_par_bit);
    else if (PARITY == 2) rx_par_bad = (^rx_shift) ^ rx_par_bit;
  end

  // The start bit re-centres the timer at its midpoint; later bits sample one full period apart.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      rx_timer   <= '0;
      rx_hi_cnt  <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_par_bit <= 1'b0;
    end else begin
      if (rx_state == RX_IDLE || rx_state == RX_ERROR)  rx_timer <= '0;
      else if (rx_state == RX_START && rx_half)         rx_timer <= '0;
      else if (rx_state != RX_START && rx_tick)         rx_timer <= '0;
      else                                              rx_timer <= rx_timer + TW'(1);

      if (rx_state == RX_ERROR) rx_hi_cnt <= rx_s ? rx_hi_cnt + TW'(1) : '0;
      else                      rx_hi_cnt <= '0;

      if (rx_state != RX_DATA) rx_bit <= '0;
      else if (rx_tick)        rx_bit <= rx_bit + BW'(1);

      if (rx_state == RX_DATA && rx_tick)
        rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
      if (rx_state == RX_PARITY && rx_tick)
        rx_par_bit <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      received     <= 1'b0;
      parity_error <= 1'b0;
      recv_error   <= 1'b0;
      rx_byte      <= '0;
    end else begin
      received     <= rx_stop_tick && rx_s;
      parity_error <= rx_stop_tick && rx_s && rx_par_bad;
      recv_error   <= rx_stop_tick && !rx_s;
      if (rx_stop_tick && rx_s) rx_byte <= rx_shift;
    end
  end

endmodule

// File: tb/tb_uart_core_param.sv
// Scoreboard bench: two instances (8E1 and 5O2), frame-level reference model, decoupled monitors.
module tb_uart_core_param;

  localparam int CPB   = 16;
  localparam int A_LEN = 1 + 8 + 1 + 1;
  localparam int B_LEN = 1 + 5 + 1 + 2;

  typedef struct { logic [15:0] bits; int len; } frame_t;
  typedef struct { logic [7:0] d; logic perr; } rx_exp_t;

  logic clk;
  logic rst_a, rst_b;
  logic rx_a, rx_b, rx_drv, loop_en;
  logic tx_a, tx_b;
  logic transmit_a, transmit_b;
  logic [7:0] tx_byte_a;
  logic [4:0] tx_byte_b;
  logic tx_ready_a, tx_ready_b;
  logic received_a, received_b;
  logic [7:0] rx_byte_a;
  logic [4:0] rx_byte_b;
  logic parity_error_a, parity_error_b, recv_error_a, recv_error_b;
  logic is_receiving_a, is_receiving_b, is_transmitting_a, is_transmitting_b;

  int vectors = 0;
  int miscompares = 0;
  int aborts_req = 0;

  frame_t  exp_tx_a[$];
  frame_t  exp_tx_b[$];
  rx_exp_t exp_rx[$];
  logic [7:0] exp_ferr[$];

  assign rx_a = loop_en ? tx_a : rx_drv;
  assign rx_b = 1'b1;

  uart_core_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .CLKS_PER_BIT(CPB)) dut_a (
    .clk(clk), .rst(rst_a), .rx(rx_a), .tx(tx_a), .transmit(transmit_a), .tx_byte(tx_byte_a),
    .tx_ready(tx_ready_a), .received(received_a), .rx_byte(rx_byte_a),
    .parity_error(parity_error_a), .recv_error(recv_error_a),
    .is_receiving(is_receiving_a), .is_transmitting(is_transmitting_a));

  uart_core_param #(.DATA_BITS(5), .PARITY(1), .STOP_BITS(2), .CLKS_PER_BIT(CPB)) dut_b (
    .clk(clk), .rst(rst_b), .rx(rx_b), .tx(tx_b), .transmit(transmit_b), .tx_byte(tx_byte_b),
    .tx_ready(tx_ready_b), .received(received_b), .rx_byte(rx_byte_b),
    .parity_error(parity_error_b), .recv_error(recv_error_b),
    .is_receiving(is_receiving_b), .is_transmitting(is_transmitting_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference frame: start, data LSB first, optional parity, stop bits.
  function automatic frame_t make_frame(input logic [7:0] d, input int db, input int par, input int sb);
    frame_t f;
    int n, ones;
    f.bits = '0;
    n = 1;
    ones = 0;
    for (int i = 0; i < db; i++) begin
      f.bits[n] = d[i];
      ones += int'(d[i]);
      n++;
    end
    if (par != 0) begin
      f.bits[n] = (par == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
      n++;
    end
    for (int i = 0; i < sb; i++) begin
      f.bits[n] = 1'b1;
      n++;
    end
    f.len = n;
    return f;
  endfunction

  function automatic logic get_tx(input int w);
    return (w == 0) ? tx_a : tx_b;
  endfunction

  function automatic logic get_ready(input int w);
    return (w == 0) ? tx_ready_a : tx_ready_b;
  endfunction

  task automatic tx_send(input int w, input logic [7:0] d);
    for (int i = 0; i < 2000; i++) begin
      if (get_ready(w)) break;
      tick();
    end
    check("tx_ready_wait", 32'(get_ready(w)), 32'd1);
    if (w == 0) begin
      tx_byte_a = d;
      transmit_a = 1'b1;
      exp_tx_a.push_back(make_frame(d, 8, 2, 1));
    end else begin
      tx_byte_b = d[4:0];
      transmit_b = 1'b1;
      exp_tx_b.push_back(make_frame(d, 5, 1, 2));
    end
    tick();
    if (w == 0) transmit_a = 1'b0;
    else        transmit_b = 1'b0;
  endtask

  task automatic measure_busy(input int w, input int exp_len, input string nm);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (get_ready(w)) break;
      cnt++;
    end
    check(nm, 32'(cnt), 32'(exp_len));
  endtask

  task automatic send_rx(input logic [7:0] d, input bit bad_par, input bit stop_val);
    frame_t f;
    f = make_frame(d, 8, 2, 1);
    if (bad_par) f.bits[9] = ~f.bits[9];
    f.bits[10] = stop_val;
    for (int k = 0; k < f.len; k++) begin
      rx_drv = f.bits[k];
      repeat (CPB) tick();
    end
  endtask

  // Samples each tx bit at its midpoint and compares the whole frame.
  task automatic mon_tx(input int w);
    frame_t e;
    logic [15:0] got;
    int len, aborts_done;
    len = (w == 0) ? A_LEN : B_LEN;
    aborts_done = 0;
    forever begin
      @(negedge clk);
      if (get_tx(w) === 1'b0) begin
        got = '0;
        repeat (CPB / 2) @(negedge clk);
        got[0] = get_tx(w);
        for (int k = 1; k < len; k++) begin
          repeat (CPB) @(negedge clk);
          got[k] = get_tx(w);
        end
        if (w == 1 && aborts_req > aborts_done) begin
          aborts_done++;
          if (exp_tx_b.size() > 0) e = exp_tx_b.pop_front();
        end else if (w == 0) begin
          if (exp_tx_a.size() == 0) check("tx_a_unexpected_frame", 32'(exp_tx_a.size()), 32'd1);
          else begin
            e = exp_tx_a.pop_front();
            check("tx_a_frame", 32'(got), 32'(e.bits));
          end
        end else begin
          if (exp_tx_b.size() == 0) check("tx_b_unexpected_frame", 32'(exp_tx_b.size()), 32'd1);
          else begin
            e = exp_tx_b.pop_front();
            check("tx_b_frame", 32'(got), 32'(e.bits));
          end
        end
      end
    end
  endtask

  initial mon_tx(0);
  initial mon_tx(1);

  initial begin : rx_monitor
    rx_exp_t e;
    logic [7:0] keep;
    forever begin
      @(negedge clk);
      if (received_a === 1'b1) begin
        if (exp_rx.size() == 0) check("rx_unexpected_received", 32'(exp_rx.size()), 32'd1);
        else begin
          e = exp_rx.pop_front();
          check("rx_byte", 32'(rx_byte_a), 32'(e.d));
          check("rx_parity_error", 32'(parity_error_a), 32'(e.perr));
        end
      end else if (parity_error_a === 1'b1) begin
        check("parity_error_without_received", 32'(received_a), 32'd1);
      end
      if (recv_error_a === 1'b1) begin
        if (exp_ferr.size() == 0) check("rx_unexpected_recv_error", 32'(exp_ferr.size()), 32'd1);
        else begin
          keep = exp_ferr.pop_front();
          check("recv_error_rx_byte_kept", 32'(rx_byte_a), 32'(keep));
          check("recv_error_no_received", 32'(received_a), 32'd0);
        end
      end
      if (received_b || recv_error_b || parity_error_b)
        check("b_rx_spurious", 32'({received_b, recv_error_b, parity_error_b}), 32'd0);
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: run still active at %0t, required completion", $time);
    $fatal(1);
  end

  initial begin : stimulus
    rst_a = 1'b0; rst_b = 1'b0; rx_drv = 1'b1; loop_en = 1'b0;
    transmit_a = 1'b0; transmit_b = 1'b0; tx_byte_a = '0; tx_byte_b = '0;
    repeat (3) @(negedge clk);
    check("in_reset_tx", 32'(tx_a), 32'd1);
    check("in_reset_tx_ready", 32'(tx_ready_a), 32'd1);
    check("in_reset_pulses_busy", 32'({received_a, parity_error_a, recv_error_a,
          is_receiving_a, is_transmitting_a}), 32'd0);
    check("in_reset_rx_byte", 32'(rx_byte_a), 32'd0);
    tick();
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (4) tick();
    check("post_reset_tx_a", 32'(tx_a), 32'd1);
    check("post_reset_tx_b", 32'(tx_b), 32'd1);
    check("post_reset_ready_b", 32'(tx_ready_b), 32'd1);
    check("post_reset_idle_a", 32'({is_receiving_a, is_transmitting_a}), 32'd0);

    // 8E1 transmit of 0xA5: 11 bits x 16 cycles busy
    tx_send(0, 8'hA5);
    measure_busy(0, 176, "tx_a5_busy_cycles");
    repeat (20) tick();

    // Loopback, back-to-back with transmit held high
    loop_en = 1'b1;
    tick();
    exp_rx.push_back('{d: 8'h3C, perr: 1'b0});
    exp_rx.push_back('{d: 8'hFF, perr: 1'b0});
    exp_tx_a.push_back(make_frame(8'h3C, 8, 2, 1));
    tx_byte_a = 8'h3C;
    transmit_a = 1'b1;
    tick();
    tx_byte_a = 8'hFF;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx_ready_a) break;
    end
    check("b2b_ready_returns", 32'(tx_ready_a), 32'd1);
    exp_tx_a.push_back(make_frame(8'hFF, 8, 2, 1));
    tick();
    check("b2b_no_gap_accept", 32'(tx_ready_a), 32'd0);
    transmit_a = 1'b0;
    repeat (200) tick();
    loop_en = 1'b0;
    repeat (10) tick();

    // Inverted parity on 0x81
    exp_rx.push_back('{d: 8'h81, perr: 1'b1});
    send_rx(8'h81, 1'b1, 1'b1);
    repeat (20) tick();

    // Framing error followed by a long break
    exp_ferr.push_back(8'h81);
    send_rx(8'h55, 1'b0, 1'b0);
    repeat (40 * CPB) tick();
    check("break_still_receiving", 32'(is_receiving_a), 32'd1);
    rx_drv = 1'b1;
    repeat (10) tick();
    check("break_release_partial", 32'(is_receiving_a), 32'd1);
    repeat (10) tick();
    check("break_release_idle", 32'(is_receiving_a), 32'd0);
    check("break_rx_byte_kept", 32'(rx_byte_a), 32'h81);

    // Short start glitch
    rx_drv = 1'b0;
    repeat (4) tick();
    check("glitch_enters_start", 32'(is_receiving_a), 32'd1);
    rx_drv = 1'b1;
    repeat (20) tick();
    check("glitch_rejected", 32'(is_receiving_a), 32'd0);

    // 5O2 transmit of 0x13: 9 bits x 16 cycles
    tx_send(1, 8'h13);
    measure_busy(1, 144, "tx_b_13_busy_cycles");
    repeat (20) tick();

    // Reset 50 cycles into a frame
    aborts_req++;
    tx_send(1, 8'h0A);
    repeat (49) tick();
    check("midtx_busy", 32'(tx_ready_b), 32'd0);
    rst_b = 1'b0;
    #1;
    check("midtx_reset_tx", 32'(tx_b), 32'd1);
    check("midtx_reset_ready", 32'(tx_ready_b), 32'd1);
    check("midtx_reset_not_tx", 32'(is_transmitting_b), 32'd0);
    repeat (3) tick();
    rst_b = 1'b1;
    repeat (200) tick();
    tx_send(1, 8'h0A);
    measure_busy(1, 144, "after_reset_busy_cycles");
    repeat (20) tick();

    // Randomised full-duplex traffic
    fork
      begin
        for (int n = 0; n < 6; n++) begin
          logic [7:0] d;
          bit bad;
          d = 8'($urandom);
          bad = ($urandom_range(0, 3) == 0);
          exp_rx.push_back('{d: d, perr: bad});
          send_rx(d, bad, 1'b1);
          repeat ($urandom_range(0, 20)) tick();
        end
      end
      begin
        for (int n = 0; n < 6; n++) begin
          tx_send(0, 8'($urandom));
          repeat ($urandom_range(0, 30)) tick();
        end
      end
      begin
        for (int n = 0; n < 6; n++) begin
          tx_send(1, 8'($urandom));
          repeat ($urandom_range(0, 30)) tick();
        end
      end
    join
    repeat (300) tick();

    check("rx_queue_drained", 32'(exp_rx.size()), 32'd0);
    check("ferr_queue_drained", 32'(exp_ferr.size()), 32'd0);
    check("tx_a_queue_drained", 32'(exp_tx_a.size()), 32'd0);
    check("tx_b_queue_drained", 32'(exp_tx_b.size()), 32'd0);
    check("b_rx_idle", 32'({is_receiving_b, rx_byte_b}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
